// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for an internal bank of JK flip-flops.
// Accepts one command at a time and drives per-bit j/k patterns.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE with clr low, so commands offered while busy are dropped.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_CNT_UP = 3'd4;
  localparam logic [2:0] OP_CNT_DN = 3'd5;
  localparam logic [2:0] OP_SHL    = 3'd6;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] steps_q;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] bank_d;
  logic [WIDTH-1:0] up_c;
  logic [WIDTH-1:0] dn_c;
  logic [WIDTH-1:0] low_m;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             multi_op;

  // Carry enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_c  = '0;
    dn_c  = '0;
    low_m = '0;
    up_c[0] = 1'b1;
    dn_c[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      low_m[i-1] = 1'b1;
      up_c[i]    = ((bank_q & low_m) == low_m);
      dn_c[i]    = ((bank_q & low_m) == '0);
    end
  end

  always_comb begin
    j_d = '0;
    k_d = '0;
    case (op_q)
      OP_SET:    j_d = mask_q;
      OP_CLEAR:  k_d = mask_q;
      OP_TOGGLE: begin j_d = mask_q; k_d = mask_q; end
      OP_CNT_UP: begin j_d = up_c;   k_d = up_c;   end
      OP_CNT_DN: begin j_d = dn_c;   k_d = dn_c;   end
      OP_SHL: begin
        j_d = {bank_q[WIDTH-2:0], mask_q[0]};
        k_d = {~bank_q[WIDTH-2:0], ~mask_q[0]};
      end
      default: begin j_d = '0; k_d = '0; end
    endcase
    if (state_q != S_EXEC || clr) begin
      j_d = '0;
      k_d = '0;
    end
  end

  assign bank_d   = (j_d & ~bank_q) | (~k_d & bank_q);
  assign multi_op = (cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN) || (cmd_op == OP_SHL);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mask_q  <= '0;
      steps_q <= '0;
      bank_q  <= '0;
    end else begin
      bank_q <= bank_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            mask_q <= cmd_mask;
            if (!multi_op) begin
              steps_q <= CNT_W'(1);
              state_q <= S_EXEC;
            end else if (cmd_count == '0) begin
              steps_q <= '0;
              state_q <= S_DONE;
            end else begin
              steps_q <= cmd_count;
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          steps_q <= steps_q - CNT_W'(1);
          if (steps_q == CNT_W'(1)) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign j_out     = j_d;
  assign k_out     = k_d;
  assign q         = bank_q;
  assign qn        = ~bank_q;
  assign cmd_ready = (state_q == S_IDLE) && !clr;
  assign busy      = ((state_q == S_EXEC) || (state_q == S_DONE)) && !clr;
  assign done      = (state_q == S_DONE) && !clr;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: hand-computed expectations for every
// opcode, count wrap, zero count, busy rejection and mid-operation reset.
module tb_jk_bank_sequencer;

  logic       clk;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_count;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic [3:0] q;
  logic [3:0] qn;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .j_out     (j_out),
    .k_out     (k_out),
    .q         (q),
    .qn        (qn),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: waits (bounded) for ready, presents one command for one edge,
  // then scrambles the operand inputs to prove they were captured at acceptance.
  task automatic issue(input logic [2:0] op, input logic [3:0] mask, input logic [7:0] count);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("issue_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = count;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd3;
    cmd_mask  = ~mask;
    cmd_count = 8'hff;
  endtask

  // Called in the DONE cycle.
  task automatic finish_cmd(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    chk({tag, "_j_done"}, {28'd0, j_out}, 32'd0);
    step();
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  // Runs a single-step op and checks the resulting bank value.
  task automatic single(input string tag, input logic [2:0] op, input logic [3:0] mask,
                        input logic [3:0] exp_q);
    issue(op, mask, 8'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
    step();
    chk({tag, "_q"}, {28'd0, q}, {28'd0, exp_q});
    chk({tag, "_qn"}, {28'd0, qn}, {28'd0, ~exp_q});
    finish_cmd(tag);
  endtask

  logic [3:0] up_seq [5];
  logic [3:0] dn_seq [3];
  logic [3:0] q_hold;

  initial begin
    up_seq = '{4'hf, 4'h0, 4'h1, 4'h2, 4'h3};
    dn_seq = '{4'h0, 4'hf, 4'he};
    clr       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_mask  = 4'd0;
    cmd_count = 8'd0;
    step();
    step();
    chk("rst_q", {28'd0, q}, 32'h0);
    chk("rst_qn", {28'd0, qn}, 32'hf);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_jk", {24'd0, j_out, k_out}, 32'd0);
    clr = 1'b0;
    #1;
    chk("rst_ready_first", {31'd0, cmd_ready}, 32'd1);

    // SET 0101: drive visible in EXEC, done two cycles after acceptance
    issue(3'd1, 4'b0101, 8'd0);
    chk("set_j", {28'd0, j_out}, 32'h5);
    chk("set_k", {28'd0, k_out}, 32'h0);
    chk("set_ready_busy", {31'd0, cmd_ready}, 32'd0);
    chk("set_nodone", {31'd0, done}, 32'd0);
    step();
    chk("set_q", {28'd0, q}, 32'h5);
    chk("set_qn", {28'd0, qn}, 32'ha);
    finish_cmd("set");

    // TOGGLE 0011 then CLEAR 0100
    issue(3'd3, 4'b0011, 8'd0);
    chk("tog_j", {28'd0, j_out}, 32'h3);
    chk("tog_k", {28'd0, k_out}, 32'h3);
    step();
    chk("tog_q", {28'd0, q}, 32'h6);
    finish_cmd("tog");
    issue(3'd2, 4'b0100, 8'd0);
    chk("clr_j", {28'd0, j_out}, 32'h0);
    chk("clr_k", {28'd0, k_out}, 32'h4);
    step();
    chk("clr_q", {28'd0, q}, 32'h2);
    finish_cmd("clrop");

    // Count up with wrap from 1110
    single("ld_e", 3'd1, 4'b1110, 4'he);
    issue(3'd4, 4'd0, 8'd5);
    chk("up_j_first", {28'd0, j_out}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("up_busy", {31'd0, busy}, 32'd1);
      chk("up_nodone", {31'd0, done}, 32'd0);
      step();
      chk("up_q", {28'd0, q}, {28'd0, up_seq[i]});
    end
    finish_cmd("up");

    // Count down from 0001
    single("ld_clr", 3'd2, 4'b1111, 4'h0);
    single("ld_1", 3'd1, 4'b0001, 4'h1);
    issue(3'd5, 4'd0, 8'd3);
    chk("dn_j_first", {28'd0, j_out}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("dn_nodone", {31'd0, done}, 32'd0);
      step();
      chk("dn_q", {28'd0, q}, {28'd0, dn_seq[i]});
    end
    finish_cmd("dn");

    // Shift left from 0011 with serial-in 0
    single("ld_clr2", 3'd2, 4'b1111, 4'h0);
    single("ld_3", 3'd1, 4'b0011, 4'h3);
    issue(3'd6, 4'b1110, 8'd2);
    chk("shl_j", {28'd0, j_out}, 32'h6);
    chk("shl_k", {28'd0, k_out}, 32'h9);
    step();
    chk("shl_q1", {28'd0, q}, 32'h6);
    chk("shl_nodone", {31'd0, done}, 32'd0);
    step();
    chk("shl_q2", {28'd0, q}, 32'hc);
    finish_cmd("shl");

    // Shift in a 1 from 0000
    single("ld_clr3", 3'd2, 4'b1111, 4'h0);
    issue(3'd6, 4'b0001, 8'd1);
    step();
    chk("shl1_q", {28'd0, q}, 32'h1);
    finish_cmd("shl1");

    // Zero-count: done one cycle after acceptance, no EXEC
    issue(3'd4, 4'd0, 8'd0);
    chk("zero_state", {30'd0, dbg_state}, 32'd2);
    chk("zero_q", {28'd0, q}, 32'h1);
    chk("zero_jk", {24'd0, j_out, k_out}, 32'd0);
    finish_cmd("zero");
    chk("zero_q_after", {28'd0, q}, 32'h1);

    // NOP and reserved opcode still take EXEC and done
    single("nop", 3'd0, 4'b1111, 4'h1);
    single("rsvd", 3'd7, 4'b1111, 4'h1);

    // Busy rejection during CNT_UP count=10
    single("ld_clr4", 3'd2, 4'b1111, 4'h0);
    issue(3'd4, 4'd0, 8'd10);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_mask  = 4'b1111;
        chk("rej_ready", {31'd0, cmd_ready}, 32'd0);
      end
      chk("rej_nodone", {31'd0, done}, 32'd0);
      step();
      cmd_valid = 1'b0;
    end
    chk("rej_q", {28'd0, q}, 32'ha);
    finish_cmd("rej");
    step();
    chk("rej_idle_busy", {31'd0, busy}, 32'd0);
    chk("rej_q_hold", {28'd0, q}, 32'ha);

    // Reset in the 3rd EXEC cycle of CNT_UP count=8
    single("ld_clr5", 3'd2, 4'b1111, 4'h0);
    issue(3'd4, 4'd0, 8'd8);
    step();
    step();
    chk("abort_q2", {28'd0, q}, 32'h2);
    clr = 1'b1;
    #1;
    chk("abort_jk_clr", {24'd0, j_out, k_out}, 32'd0);
    chk("abort_ready_clr", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("abort_q", {28'd0, q}, 32'h0);
    chk("abort_qn", {28'd0, qn}, 32'hf);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    clr = 1'b0;
    #1;
    chk("abort_ready_first", {31'd0, cmd_ready}, 32'd1);
    q_hold = q;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", {31'd0, done}, 32'd0);
      chk("abort_q_stays", {28'd0, q}, {28'd0, q_hold});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven controller that sequences a bank of WIDTH JK flip-flops. It accepts one command at a time through a valid/ready handshake and translates it into per-bit j/k drive patterns for one or more clock cycles. Supported commands are set, clear, toggle, synchronous up/down count and serial shift. The block sits between a host/control FSM and the JK storage bank, and owns that bank internally.

## Interface
- WIDTH, 4, number of JK bits in the bank (≥2)
- CNT_W, 8, width of the step-count operand

- clk  in  1  rising-edge clock
- clr  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  3  opcode: 0 NOP, 1 SET, 2 CLEAR, 3 TOGGLE, 4 CNT_UP, 5 CNT_DN, 6 SHL, 7 reserved (treated as NOP)
- cmd_mask  in  WIDTH  bit select for SET/CLEAR/TOGGLE; bit 0 is the serial-in value for SHL; ignored for other ops
- cmd_count  in  CNT_W  step count for CNT_UP/CNT_DN/SHL; ignored for other ops
- j_out  out  WIDTH  j drive applied to the bank this cycle
- k_out  out  WIDTH  k drive applied to the bank this cycle
- q  out  WIDTH  bank state
- qn  out  WIDTH  always ~q
- busy  out  1  high in EXEC and DONE
- done  out  1  one-cycle completion pulse

## Operation
- **Bank semantics, per bit, per rising edge:**
  - j=0, k=0: hold
  - j=0, k=1: q←0
  - j=1, k=0: q←1
  - j=1, k=1: q←~q
- **FSM states:** IDLE, EXEC, DONE.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch op, mask and count.
  - Single-step ops (SET/CLEAR/TOGGLE/NOP/reserved) go to EXEC with steps=1.
  - Multi-step ops (CNT_UP/CNT_DN/SHL) with count≠0 go to EXEC with steps=count.
  - Multi-step ops with count=0 go directly to DONE.
- **EXEC:**
  - Drive j_out/k_out as defined below and decrement the step counter.
  - Go to DONE when the last step has been applied.
- **DONE:** assert done for one cycle, then return to IDLE.
- **Drive patterns.** m is the latched mask, c[i] is the carry/borrow enable.
  - SET: j=m, k=0.
  - CLEAR: j=0, k=m.
  - TOGGLE: j=k=m.
  - NOP/reserved: j=k=0. EXEC and done still occur.
  - CNT_UP: j=k=c, where c[0]=1 and c[i]=&q[i-1:0]. Wraps modulo 2^WIDTH.
  - CNT_DN: j=k=c, where c[0]=1 and c[i]=&qn[i-1:0]. Wraps modulo 2^WIDTH.
  - SHL: for i≥1, j[i]=q[i-1] and k[i]=qn[i-1]; j[0]=m[0], k[0]=~m[0]. The MSB is discarded.
- j_out/k_out are 0 in IDLE, in DONE, and during clr.
- **Command acceptance:**
  - cmd_valid while busy is ignored; the command is not latched or queued.
  - Operands are captured at acceptance only. Input changes after acceptance have no effect.
- **Reset:**
  - clr sampled high: state←IDLE, q←0, qn←all ones, step counter←0.
  - done=0, busy=0, cmd_ready=0 while clr is high.
  - Reset mid-operation aborts the command: remaining steps are dropped and no done pulse is issued.

## Timing
- Command accepted at edge N. EXEC occupies cycles N+1 … N+S, where S is the number of steps.
- q reflects step s after the edge ending EXEC cycle N+s.
- done is high in cycle N+S+1; cmd_ready returns high in cycle N+S+2.
- Single-step op: q updated after edge N+1, done in N+2, next accept possible at edge N+3.
- count=0: done in N+1, q unchanged, cmd_ready high in N+2.
- Count/shift patterns are combinational from the current q, so every EXEC cycle advances exactly one step. Throughput is 1 step/cycle.
- Max latency: 2^CNT_W−1 steps + 2 cycles of overhead.
- After clr deasserts, cmd_ready is 1 in the first cycle.

## Test plan
- **SET:** reset, then SET mask=0101 from q=0000 → j_out=0101 and k_out=0000 in EXEC; q=0101; done exactly 2 cycles after acceptance; qn=1010.
- **TOGGLE, then CLEAR:** from q=0101, TOGGLE mask=0011 → q=0110. Then CLEAR mask=0100 → q=0010.
- **Count with wrap:** load 1110 via SET, then CNT_UP count=5 → q sequence 1111, 0000, 0001, 0010, 0011; done after the 5th step. Then CNT_DN count=3 from 0001 (reload via CLEAR/SET) → 0000, 1111, 1110.
- **Shift and zero-count:** from q=0011, SHL count=2 with mask[0]=0 → 0110, 1100. SHL with mask[0]=1 from 0000 → 0001. CNT_UP count=0 → done one cycle after acceptance, q unchanged, no EXEC cycle.
- **Busy rejection:** during a CNT_UP count=10, pulse cmd_valid with SET mask=1111 → not accepted, cmd_ready stays 0, and the final q equals the pure count result.
- **Reset mid-operation:** assert clr in the 3rd EXEC cycle of CNT_UP count=8 → next cycle q=0000, qn=1111, busy=0, no done pulse; cmd_ready=1 in the first cycle after clr drops.
